// File: rtl/demultiplexer_1_to_2_16_bit_stream.sv
// Registered 1-to-2 stream demultiplexer: S steers each accepted word into one of two
// independently drained holding registers, with per-channel delivery counters.
module demultiplexer_1_to_2_16_bit_stream #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 S,
  input  logic [WIDTH-1:0]     I,
  input  logic                 I_VALID,
  output logic                 I_READY,
  output logic [WIDTH-1:0]     Y0,
  output logic                 Y0_VALID,
  input  logic                 Y0_READY,
  output logic [WIDTH-1:0]     Y1,
  output logic                 Y1_VALID,
  input  logic                 Y1_READY,
  output logic [CNT_WIDTH-1:0] CNT0,
  output logic [CNT_WIDTH-1:0] CNT1
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t               r_state0;
  state_t               r_state1;
  logic [WIDTH-1:0]     r_y0;
  logic [WIDTH-1:0]     r_y1;
  logic [CNT_WIDTH-1:0] r_cnt0;
  logic [CNT_WIDTH-1:0] r_cnt1;

  logic w_full0;
  logic w_full1;
  logic w_ready0;
  logic w_ready1;
  logic w_accept;
  logic w_load0;
  logic w_load1;
  logic w_drain0;
  logic w_drain1;

  assign w_full0  = (r_state0 == ST_FULL);
  assign w_full1  = (r_state1 == ST_FULL);

  // A channel can take a word if empty, or if its current word leaves on this edge.
  assign w_ready0 = !w_full0 || Y0_READY;
  assign w_ready1 = !w_full1 || Y1_READY;

  always_comb begin
    I_READY = w_ready0;
    if (S) begin
      I_READY = w_ready1;
    end
  end

  assign w_accept = I_VALID && I_READY;
  assign w_load0  = w_accept && !S;
  assign w_load1  = w_accept && S;
  assign w_drain0 = w_full0 && Y0_READY;
  assign w_drain1 = w_full1 && Y1_READY;

  // Channel 0 holding register; data is kept after a drain, only reset clears it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state0 <= ST_EMPTY;
      r_y0     <= '0;
    end else begin
      case (r_state0)
        ST_EMPTY: begin
          if (w_load0) begin
            r_state0 <= ST_FULL;
            r_y0     <= I;
          end
        end
        ST_FULL: begin
          if (w_load0) begin
            r_y0     <= I;
          end else if (w_drain0) begin
            r_state0 <= ST_EMPTY;
          end
        end
        default: begin
          r_state0 <= ST_EMPTY;
        end
      endcase
    end
  end

  // Channel 1 holding register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state1 <= ST_EMPTY;
      r_y1     <= '0;
    end else begin
      case (r_state1)
        ST_EMPTY: begin
          if (w_load1) begin
            r_state1 <= ST_FULL;
            r_y1     <= I;
          end
        end
        ST_FULL: begin
          if (w_load1) begin
            r_y1     <= I;
          end else if (w_drain1) begin
            r_state1 <= ST_EMPTY;
          end
        end
        default: begin
          r_state1 <= ST_EMPTY;
        end
      endcase
    end
  end

  // Delivery counters wrap silently.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_drain0) begin
        r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
      end
      if (w_drain1) begin
        r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
      end
    end
  end

  assign Y0       = r_y0;
  assign Y1       = r_y1;
  assign Y0_VALID = w_full0;
  assign Y1_VALID = w_full1;
  assign CNT0     = r_cnt0;
  assign CNT1     = r_cnt1;

endmodule
